// File: rtl/clock_pkg.sv
// clock_pkg: shared constants and mode-state encoding for the digital clock core.
// Contents:
//   SEC_MAX, MIN_MAX, HR_MAX : terminal values of the seconds/minutes/hours counters
//   mode_t                   : mode FSM encoding; the values match the set_field codes
package clock_pkg;

  localparam logic [7:0] SEC_MAX = 8'd59;
  localparam logic [7:0] MIN_MAX = 8'd59;
  localparam logic [7:0] HR_MAX  = 8'd23;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } mode_t;

endpackage

// File: rtl/time_keeper_mod_counter.sv
// mod_counter: 8-bit modulo counter that wraps MAX -> 0.
// Parameters:
//   MAX   : terminal value; the counter runs 0..MAX
// Ports:
//   clk   in  1  rising-edge clock
//   reset in  1  synchronous active-high reset (value -> 0)
//   inc   in  1  advance by one on this edge
//   clr   in  1  synchronous clear; wins over inc
//   value out 8  current count
//   carry out 1  combinational: inc && value == MAX (wrap happens on this edge)
module mod_counter #(
  parameter logic [7:0] MAX = 8'd59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value,
  output logic       carry
);

  assign carry = inc && (value == MAX);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      value <= 8'd0;
    end else if (inc) begin
      value <= (value == MAX) ? 8'd0 : value + 8'd1;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// time_keeper: timekeeping core. Divides clk down to a one-second tick and keeps
// seconds/minutes/hours as binary counts; a mode FSM (RUN -> SET_HR -> SET_MIN -> RUN)
// lets the user set hours and minutes with mode_btn / inc_btn pulses.
// Optional build macro: TWELVE_HOUR_EN selects 12-hour output formatting with a pm flag;
// without it hours is the raw 0..23 register and pm is 0.
// Parameters:
//   CLK_HZ    : clk frequency in Hz (>= 2); prescaler terminal count is CLK_HZ-1
// Ports:
//   clk       in  1  system clock
//   reset     in  1  synchronous active-high reset
//   en        in  1  count enable; low freezes the prescaler
//   mode_btn  in  1  one-cycle pulse, advances the mode FSM
//   inc_btn   in  1  one-cycle pulse, increments the field being set
//   seconds   out 8  0..59
//   minutes   out 8  0..59
//   hours     out 8  0..23, or 1..12 with TWELVE_HOUR_EN
//   pm        out 1  PM flag (0 without TWELVE_HOUR_EN)
//   sec_tick  out 1  high in the cycle the advanced seconds count is first visible
//   set_field out 2  exposed FSM state: 00 run, 01 hours, 10 minutes
// Handshake: none; mode_btn and inc_btn are single-cycle pulses sampled on the rising edge,
// and a simultaneous inc_btn is dropped in favour of the mode transition.
module time_keeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [7:0] seconds,
  output logic [7:0] minutes,
  output logic [7:0] hours,
  output logic       pm,
  output logic       sec_tick,
  output logic [1:0] set_field
);

  localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_TERM = PW'(CLK_HZ - 1);

  mode_t         state;
  logic [PW-1:0] presc;
  logic [7:0]    hr_reg;

  logic tick_now;
  logic sec_inc, min_inc, hr_inc, sec_clr;
  logic sec_carry, min_carry, hr_carry_unused;
  logic set_inc;

  // A tick is due this edge: running, enabled and at the terminal count.
  assign tick_now = (state == RUN) && en && (presc == PRESC_TERM);
  // Set-mode increment is dropped when mode_btn arrives in the same cycle.
  assign set_inc  = inc_btn && !mode_btn;

  assign sec_inc = tick_now;
  assign sec_clr = (state == SET_MIN) && mode_btn;
  assign min_inc = (state == RUN)     ? sec_carry : ((state == SET_MIN) && set_inc);
  assign hr_inc  = (state == RUN)     ? min_carry : ((state == SET_HR)  && set_inc);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      presc    <= '0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= tick_now;
      if (state == RUN) begin
        if (en) begin
          presc <= (presc == PRESC_TERM) ? '0 : presc + 1'b1;
        end
      end else begin
        presc <= '0;
      end
      if (mode_btn) begin
        case (state)
          RUN:     state <= SET_HR;
          SET_HR:  state <= SET_MIN;
          default: state <= RUN;
        endcase
      end
    end
  end

  mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk(clk), .reset(reset), .inc(sec_inc), .clr(sec_clr),
    .value(seconds), .carry(sec_carry)
  );

  mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk(clk), .reset(reset), .inc(min_inc), .clr(1'b0),
    .value(minutes), .carry(min_carry)
  );

  mod_counter #(.MAX(HR_MAX)) u_hr (
    .clk(clk), .reset(reset), .inc(hr_inc), .clr(1'b0),
    .value(hr_reg), .carry(hr_carry_unused)
  );

  assign set_field = state;

`ifdef TWELVE_HOUR_EN
  always_comb begin
    hours = hr_reg;
    if (hr_reg == 8'd0) begin
      hours = 8'd12;
    end else if (hr_reg > 8'd12) begin
      hours = hr_reg - 8'd12;
    end
    pm = (hr_reg >= 8'd12);
  end
`else
  assign hours = hr_reg;
  assign pm    = 1'b0;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: self-checking bench for time_keeper with CLK_HZ = 4.
// The reference model keeps time of day as a plain seconds count and the prescaler
// as "enabled cycles since the last tick"; each cycle it pushes an expected output
// snapshot which is compared with the DUT 1 time unit after the rising edge.
module tb_time_keeper;

  localparam int CLK_HZ = 4;
  localparam int W = 28;

  logic       clk = 1'b0;
  logic       reset, en, mode_btn, inc_btn;
  logic [7:0] seconds, minutes, hours;
  logic       pm, sec_tick;
  logic [1:0] set_field;

  time_keeper #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .reset(reset), .en(en), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .seconds(seconds), .minutes(minutes), .hours(hours), .pm(pm),
    .sec_tick(sec_tick), .set_field(set_field)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_tod;      // seconds of day, 0..86399
  int m_mode;     // 0 run, 1 set hours, 2 set minutes
  int m_elapsed;  // enabled run cycles since last tick
  bit m_tick;

  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int disp_hours(input int h);
`ifdef TWELVE_HOUR_EN
    return (h % 12 == 0) ? 12 : h % 12;
`else
    return h;
`endif
  endfunction

  function automatic int disp_pm(input int h);
`ifdef TWELVE_HOUR_EN
    return (h >= 12) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic model_step(input bit r, input bit e, input bit mb, input bit ib);
    int h, m, s;
    m_tick = 0;
    if (r) begin
      m_tod = 0; m_mode = 0; m_elapsed = 0;
    end else begin
      h = m_tod / 3600; m = (m_tod / 60) % 60; s = m_tod % 60;
      if (m_mode == 0) begin
        if (e) begin
          m_elapsed++;
          if (m_elapsed == CLK_HZ) begin
            m_elapsed = 0;
            m_tod = (m_tod + 1) % 86400;
            m_tick = 1;
          end
        end
      end else begin
        m_elapsed = 0;
        if (ib && !mb) begin
          if (m_mode == 1) h = (h + 1) % 24;
          else             m = (m + 1) % 60;
          m_tod = h * 3600 + m * 60 + s;
        end
      end
      if (mb) begin
        if (m_mode == 2) m_tod = m_tod - (m_tod % 60);
        m_mode = (m_mode + 1) % 3;
      end
    end
    h = m_tod / 3600;
    exp_q.push_back({8'(m_tod % 60), 8'((m_tod / 60) % 60), 8'(disp_hours(h)),
                     1'(disp_pm(h)), m_tick, 2'(m_mode)});
  endtask

  task automatic compare_outputs();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check("seconds",   int'(seconds),   int'(e[27:20]));
    check("minutes",   int'(minutes),   int'(e[19:12]));
    check("hours",     int'(hours),     int'(e[11:4]));
    check("pm",        int'(pm),        int'(e[3]));
    check("sec_tick",  int'(sec_tick),  int'(e[2]));
    check("set_field", int'(set_field), int'(e[1:0]));
  endtask

  // driver: apply inputs, clock one edge, advance model, compare
  task automatic cycle(input bit r, input bit e, input bit mb, input bit ib);
    reset = r; en = e; mode_btn = mb; inc_btn = ib;
    @(posedge clk);
    model_step(r, e, mb, ib);
    #1;
    compare_outputs();
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, 0);
  endtask

  task automatic press_mode();
    cycle(0, 1, 1, 0);
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, 1);
  endtask

  initial begin
    int wait_cycles;
    bit got_tick;
    reset = 1; en = 0; mode_btn = 0; inc_btn = 0;

    // reset state and free run
    do_reset();
    check("rst_seconds", int'(seconds), 0);
    check("rst_hours", int'(hours), disp_hours(0));
    check("rst_set_field", int'(set_field), 0);
    run(3);
    check("no_tick_before_4", int'(sec_tick), 0);
    run(1);
    check("first_tick_at_4", int'(sec_tick), 1);
    check("sec_after_4", int'(seconds), 1);
    run(232);
    check("sec_after_236", int'(seconds), 59);
    run(4);
    check("tick60_sec", int'(seconds), 0);
    check("tick60_min", int'(minutes), 1);

    // preload 23:59:58 and roll over midnight
    do_reset();
    press_mode();
    press_inc(23);
    press_mode();
    press_inc(59);
    press_mode();
    run(58 * CLK_HZ);
    check("preload_sec", int'(seconds), 58);
    run(CLK_HZ);
    check("pre_midnight_sec", int'(seconds), 59);
    check("pre_midnight_hr", int'(hours), disp_hours(23));
    run(CLK_HZ);
    check("midnight_tick", int'(sec_tick), 1);
    check("midnight_min", int'(minutes), 0);
    check("midnight_hr", int'(hours), disp_hours(0));

    // hours set with wrap
    do_reset();
    run(2);
    press_mode();
    press_inc(25);
    check("set_hr_wrap", int'(hours), disp_hours(1));
    check("set_hr_min", int'(minutes), 0);

    // simultaneous mode/inc in SET_MIN, then tick exactly CLK_HZ later
    press_mode();
    press_inc(7);
    cycle(0, 1, 1, 1);
    check("both_btn_mode", int'(set_field), 0);
    check("both_btn_min", int'(minutes), 7);
    check("both_btn_sec", int'(seconds), 0);
    run(CLK_HZ - 1);
    check("exit_no_early_tick", int'(sec_tick), 0);
    run(1);
    check("exit_tick_at_4", int'(sec_tick), 1);

    // en held low mid-count
    do_reset();
    run(2);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
    check("en_low_no_advance", int'(seconds), 0);
    wait_cycles = 0; got_tick = 0;
    while (!got_tick && wait_cycles < 10) begin
      cycle(0, 1, 0, 0);
      wait_cycles++;
      got_tick = sec_tick;
    end
    check("en_resume_latency", wait_cycles, 2);

    // 12/24-hour formatting at hour register 0, 11, 12, 13, 23
    do_reset();
    press_mode();
    check("fmt_h0", int'(hours), disp_hours(0));
    press_inc(11);
    check("fmt_h11", int'(hours), disp_hours(11));
    press_inc(1);
    check("fmt_h12_pm", int'(pm), disp_pm(12));
    press_inc(1);
    check("fmt_h13", int'(hours), disp_hours(13));
    press_inc(10);
    check("fmt_h23", int'(hours), disp_hours(23));
    cycle(1, 1, 0, 0);
    check("rst_in_set_field", int'(set_field), 0);
    check("rst_in_set_hours", int'(hours), disp_hours(0));
    check("rst_in_set_pm", int'(pm), 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 9) != 0,
            $urandom_range(0, 29) == 0,
            $urandom_range(0, 3) == 0);
    end

    if (exp_q.size() != 0) check("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
